acc_serializer: RTL and testbench

Parallel-in, serial-out transmitter for the MAC unit's result path. It captures one WIDTH-bit accumulator word through a valid/ready load port and shifts it out MSB-first, one bit per accepted beat, on a valid/ready serial port. An optional odd-parity beat can follow the data bits. It is the sending end of the serial result link: the latch-based accumulator storage is written in parallel, and this block reads it out bit-serially to the downstream capture stage.

---
 rtl/acc_serializer.sv | 90 +++++++++
 tb/tb_acc_serializer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_serializer.sv
// acc_serializer: parallel-in, serial-out transmitter for the MAC result path.
// Captures one WIDTH-bit word over a valid/ready load port and sends it MSB-first,
// one bit per accepted beat, with an optional trailing odd-parity beat.
module acc_serializer #(
  parameter int unsigned WIDTH     = 16,
  parameter bit          PARITY_EN = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_data,
  output logic             ser_last,
  output logic             busy
);

  localparam int unsigned     CntW   = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntMax = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StData   = 2'd1,
    StParity = 2'd2
  } state_e;

  state_e           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [CntW-1:0]  r_cnt;
  logic             r_par;

  logic w_beat;
  logic w_last_beat;
  logic w_load;

  // Output decode from state; load_ready also opens on the accepted final beat
  // so a new frame can follow with no bubble. Gated by rst_n so it stays low in reset.
  always_comb begin
    ser_valid = (r_state != StIdle);
    ser_data  = 1'b0;
    ser_last  = 1'b0;
    unique case (r_state)
      StData: begin
        ser_data = r_shreg[WIDTH-1];
        ser_last = (r_cnt == '0) && !PARITY_EN;
      end
      StParity: begin
        ser_data = r_par;
        ser_last = 1'b1;
      end
      default: ;
    endcase
    busy        = ser_valid;
    w_beat      = ser_valid && ser_ready;
    w_last_beat = w_beat && ser_last;
    load_ready  = rst_n && ((r_state == StIdle) || w_last_beat);
    w_load      = load_valid && load_ready;
  end

  // Frame FSM: a load (only possible in the ready window) overrides the beat update;
  // otherwise an accepted beat shifts the word and walks the counter down to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_shreg <= '0;
      r_cnt   <= '0;
      r_par   <= 1'b0;
    end else if (w_load) begin
      r_shreg <= load_data;
      r_cnt   <= CntMax;
      r_par   <= ~^load_data;
      r_state <= StData;
    end else if (w_beat) begin
      if (r_state == StData) begin
        r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
        if (r_cnt == '0) begin
          // Counter holds at zero; the state change ends the data phase.
          r_state <= PARITY_EN ? StParity : StIdle;
        end else begin
          r_cnt <= r_cnt - CntW'(1);
        end
      end else begin
        r_state <= StIdle;
      end
    end
  end

endmodule

// File: tb/tb_acc_serializer.sv
// Scoreboard bench for acc_serializer: one instance without parity, one with parity,
// both WIDTH=8. Stimulus pushes expected {data,last} beats; monitors pop on accepted beats.
module tb_acc_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       lv0, lr0, sv0, sr0, sd0, sl0, bz0;
  logic       lv1, lr1, sv1, sr1, sd1, sl1, bz1;
  logic [7:0] ld0, ld1;

  acc_serializer #(.WIDTH(8), .PARITY_EN(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .load_valid(lv0), .load_ready(lr0), .load_data(ld0),
    .ser_valid(sv0), .ser_ready(sr0), .ser_data(sd0), .ser_last(sl0), .busy(bz0)
  );

  acc_serializer #(.WIDTH(8), .PARITY_EN(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .load_valid(lv1), .load_ready(lr1), .load_data(ld1),
    .ser_valid(sv1), .ser_ready(sr1), .ser_data(sd1), .ser_last(sl1), .busy(bz1)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [1:0] q0[$];
  logic [1:0] q1[$];
  int beats0 = 0, beats1 = 0, run0 = 0, maxrun0 = 0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  // Monitor for the non-parity instance; also tracks the longest run of valid cycles.
  initial begin
    logic [1:0] e;
    forever begin
      @(negedge clk);
      if (sv0 === 1'b1) run0++;
      else run0 = 0;
      if (run0 > maxrun0) maxrun0 = run0;
      if (sv0 === 1'b1 && sr0 === 1'b1) begin
        beats0++;
        if (q0.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL dut0 unexpected beat: got data=%0b last=%0b, expected none", sd0, sl0);
        end else begin
          e = q0.pop_front();
          check($sformatf("dut0 beat %0d {data,last}", beats0), {30'd0, sd0, sl0}, {30'd0, e});
        end
      end
    end
  end

  // Monitor for the parity instance.
  initial begin
    logic [1:0] e;
    forever begin
      @(negedge clk);
      if (sv1 === 1'b1 && sr1 === 1'b1) begin
        beats1++;
        if (q1.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL dut1 unexpected beat: got data=%0b last=%0b, expected none", sd1, sl1);
        end else begin
          e = q1.pop_front();
          check($sformatf("dut1 beat %0d {data,last}", beats1), {30'd0, sd1, sl1}, {30'd0, e});
        end
      end
    end
  end

  // Expected beats for one frame: MSB first, then the hand-computed parity bit if enabled.
  task automatic push(input int id, input logic [7:0] d, input logic p);
    for (int i = 7; i >= 0; i--) begin
      if (id == 0) q0.push_back({d[i], (i == 0)});
      else         q1.push_back({d[i], 1'b0});
    end
    if (id == 1) q1.push_back({p, 1'b1});
  endtask

  // Drive a word and hold load_valid until it is accepted; returns 1ns after the load edge
  // with load_valid still high so a caller can chain a second word with no gap.
  task automatic send(input int id, input logic [7:0] d, input logic p);
    bit ok = 0;
    if (id == 0) begin lv0 = 1'b1; ld0 = d; end
    else         begin lv1 = 1'b1; ld1 = d; end
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if ((id == 0) ? lr0 : lr1) begin
        ok = 1;
        break;
      end
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL dut%0d load of %02h: got no load_ready in 60 cycles, expected acceptance",
               id, d);
    end else begin
      push(id, d, p);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int id);
    bit ok = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!((id == 0) ? bz0 : bz1)) begin
        ok = 1;
        break;
      end
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL dut%0d wait idle: got busy after 100 cycles, expected idle", id);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    lv0 = 1'b0; lv1 = 1'b0; ld0 = 8'h00; ld1 = 8'h00;
    sr0 = 1'b1; sr1 = 1'b1;

    // Reset with random inputs: all outputs low.
    repeat (3) begin
      @(posedge clk); #1;
      lv0 = 1'($urandom); ld0 = 8'($urandom); sr0 = 1'($urandom);
      lv1 = 1'($urandom); ld1 = 8'($urandom); sr1 = 1'($urandom);
      @(negedge clk);
      check("reset ser_valid0", {31'd0, sv0}, 0);
      check("reset load_ready0", {31'd0, lr0}, 0);
      check("reset busy0", {31'd0, bz0}, 0);
      check("reset ser_data0", {31'd0, sd0}, 0);
      check("reset ser_last0", {31'd0, sl0}, 0);
      check("reset ser_valid1", {31'd0, sv1}, 0);
      check("reset load_ready1", {31'd0, lr1}, 0);
    end
    @(posedge clk); #1;
    lv0 = 1'b0; lv1 = 1'b0; sr0 = 1'b1; sr1 = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post-reset load_ready0", {31'd0, lr0}, 1);
    check("post-reset load_ready1", {31'd0, lr1}, 1);
    check("post-reset busy0", {31'd0, bz0}, 0);
    @(posedge clk); #1;

    // Basic frame 0xA5, no parity.
    beats0 = 0; maxrun0 = 0;
    send(0, 8'hA5, 1'b0);
    lv0 = 1'b0;
    check("latency ser_valid0", {31'd0, sv0}, 1);
    check("latency ser_data0 msb", {31'd0, sd0}, 1);
    wait_idle(0);
    check("A5 accepted beats", beats0, 8);
    check("A5 valid run", maxrun0, 8);
    check("A5 queue drained", q0.size(), 0);
    @(negedge clk);
    check("A5 idle load_ready0", {31'd0, lr0}, 1);
    @(posedge clk); #1;

    // Parity frames: 0xA5 -> parity 1, 0x07 -> parity 0, chained.
    beats1 = 0;
    send(1, 8'hA5, 1'b1);
    send(1, 8'h07, 1'b0);
    lv1 = 1'b0;
    wait_idle(1);
    check("parity accepted beats", beats1, 18);
    check("parity queue drained", q1.size(), 0);

    // Back-pressure on 0x80: first beat held for 3 cycles.
    beats0 = 0;
    send(0, 8'h80, 1'b0);
    lv0 = 1'b0;
    sr0 = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("bp ser_valid0", {31'd0, sv0}, 1);
      check("bp ser_data0", {31'd0, sd0}, 1);
      check("bp ser_last0", {31'd0, sl0}, 0);
      check("bp cnt frozen", {29'd0, u_dut0.r_cnt}, 7);
    end
    @(posedge clk); #1;
    sr0 = 1'b1;
    wait_idle(0);
    check("bp accepted beats", beats0, 8);
    check("bp queue drained", q0.size(), 0);

    // Back-to-back 0xFF then 0x00 with load_valid held: 16 contiguous beats.
    beats0 = 0; maxrun0 = 0;
    send(0, 8'hFF, 1'b0);
    send(0, 8'h00, 1'b0);
    lv0 = 1'b0;
    wait_idle(0);
    check("b2b accepted beats", beats0, 16);
    check("b2b valid run", maxrun0, 16);
    check("b2b queue drained", q0.size(), 0);

    // Reset after 3 accepted beats of 0xA5, then a clean 0x3C frame.
    beats0 = 0;
    send(0, 8'hA5, 1'b0);
    lv0 = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset accepted beats", beats0, 3);
    check("midreset ser_valid0", {31'd0, sv0}, 0);
    check("midreset busy0", {31'd0, bz0}, 0);
    check("midreset load_ready0", {31'd0, lr0}, 0);
    q0.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    beats0 = 0;
    send(0, 8'h3C, 1'b0);
    lv0 = 1'b0;
    wait_idle(0);
    check("3C accepted beats", beats0, 8);
    check("3C queue drained", q0.size(), 0);

    check("final queue1 drained", q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
